// File: rtl/snake_pkg.sv
// Shared constants for the snake playfield: tile codes, geometry, palette and
// scheduler state encoding.
package snake_pkg;

    localparam int unsigned TILE_COLS  = 40;
    localparam int unsigned TILE_ROWS  = 30;
    localparam int unsigned TILE_SHIFT = 4;
    localparam int unsigned TILE_NUM   = TILE_COLS * TILE_ROWS;
    localparam int unsigned H_DISP     = 640;
    localparam int unsigned V_DISP     = 480;

    localparam logic [1:0] TILE_EMPTY = 2'd0;
    localparam logic [1:0] TILE_BODY  = 2'd1;
    localparam logic [1:0] TILE_HEAD  = 2'd2;
    localparam logic [1:0] TILE_FOOD  = 2'd3;

    localparam logic [15:0] COL_EMPTY = 16'h0000;
    localparam logic [15:0] COL_BODY  = 16'h07E0;
    localparam logic [15:0] COL_HEAD  = 16'hFFE0;
    localparam logic [15:0] COL_FOOD  = 16'hF800;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StLast,
        StGm
    } sched_state_e;

    function automatic logic [15:0] tile_colour(input logic [1:0] code);
        logic [15:0] col;
        unique case (code)
            TILE_EMPTY: col = COL_EMPTY;
            TILE_BODY:  col = COL_BODY;
            TILE_HEAD:  col = COL_HEAD;
            TILE_FOOD:  col = COL_FOOD;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/snake_tile_ram.sv
// Single-port tile RAM, one 2-bit code per tile, synchronous read with one
// cycle latency. Contents are not reset.
module snake_tile_ram
    import snake_pkg::*;
(
    input  logic        vga_clk,
    input  logic        we_i,
    input  logic [10:0] addr_i,
    input  logic [1:0]  wdata_i,
    output logic [1:0]  rdata_o
);

    logic [1:0] mem [TILE_NUM];

    always_ff @(posedge vga_clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/snake_tile_scheduler.sv
// Arbitrates the tile RAM between line-buffer prefetch (always first) and
// round-robin game reads/writes, and renders RGB565 pixels from the line buffer.
module snake_tile_scheduler
    import snake_pkg::*;
(
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        vga_vs,
    input  logic [9:0]  pixel_xpos,
    input  logic [9:0]  pixel_ypos,
    output logic [15:0] pixel_data,
    input  logic        gm_wr_req,
    input  logic [10:0] gm_wr_addr,
    input  logic [1:0]  gm_wr_data,
    output logic        gm_wr_ack,
    input  logic        gm_rd_req,
    input  logic [10:0] gm_rd_addr,
    output logic [1:0]  gm_rd_data,
    output logic        gm_rd_ack
);

    sched_state_e state_q;
    logic [5:0]   col_q;
    logic [4:0]   row_q;
    logic [4:0]   pend_row_q;
    logic         pend_q;
    logic         rr_q;
    logic         gnt_wr_q;
    logic         rd_valid_q;
    logic         vs_q;
    logic         fn_cond_q;
    logic         wr_ack_q;
    logic         rd_ack_q;
    logic [15:0]  pixel_data_q;
    logic [1:0]   linebuf_q [TILE_COLS];

    logic        fn_cond, f0, fn, trig;
    logic [4:0]  trig_row;
    logic        rd_pend, wr_pend, pick_wr;
    logic [10:0] fetch_addr, gm_addr, ram_addr;
    logic        gm_addr_ok, ram_we;
    logic [1:0]  ram_rdata;
    logic [5:0]  pix_col;

    // Both triggers are edge-detected so a held coordinate fetches only once.
    assign fn_cond = (pixel_xpos == 10'(H_DISP)) && (pixel_ypos != '0)
                     && (pixel_ypos[TILE_SHIFT-1:0] == '0) && (pixel_ypos < 10'(V_DISP));
    assign f0       = vga_vs & ~vs_q;
    assign fn       = fn_cond & ~fn_cond_q;
    assign trig     = f0 | fn;
    assign trig_row = f0 ? '0 : pixel_ypos[TILE_SHIFT +: 5];

    // A request being acked this cycle is not yet dropped by its owner; ignore it.
    assign rd_pend = gm_rd_req & ~rd_ack_q;
    assign wr_pend = gm_wr_req & ~wr_ack_q;
    assign pick_wr = wr_pend & (~rd_pend | rr_q);

    assign fetch_addr = 11'(row_q) * 11'(TILE_COLS) + 11'(col_q);
    assign gm_addr    = gnt_wr_q ? gm_wr_addr : gm_rd_addr;
    assign gm_addr_ok = gm_addr < 11'(TILE_NUM);

    always_comb begin
        ram_addr = '0;
        ram_we   = 1'b0;
        case (state_q)
            StFetch: ram_addr = fetch_addr;
            StGm: begin
                if (gm_addr_ok) begin
                    ram_addr = gm_addr;
                    ram_we   = gnt_wr_q;
                end
            end
            default: ;
        endcase
    end

    snake_tile_ram u_ram (
        .vga_clk (vga_clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (gm_wr_data),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            col_q      <= '0;
            row_q      <= '0;
            pend_row_q <= '0;
            pend_q     <= 1'b0;
            rr_q       <= 1'b0;
            gnt_wr_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            vs_q       <= 1'b1;
            fn_cond_q  <= 1'b0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            for (int unsigned i = 0; i < TILE_COLS; i++) begin
                linebuf_q[i] <= '0;
            end
        end else begin
            vs_q      <= vga_vs;
            fn_cond_q <= fn_cond;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            if (trig && state_q != StIdle) begin
                pend_q     <= 1'b1;
                pend_row_q <= trig_row;
            end
            case (state_q)
                StIdle: begin
                    if (trig || pend_q) begin
                        state_q <= StFetch;
                        col_q   <= '0;
                        row_q   <= trig ? trig_row : pend_row_q;
                        pend_q  <= 1'b0;
                    end else if (rd_pend || wr_pend) begin
                        state_q  <= StGm;
                        gnt_wr_q <= pick_wr;
                        rr_q     <= ~rr_q;
                    end
                end
                StFetch: begin
                    // RAM data lags the issued column by one cycle.
                    if (col_q != '0) begin
                        linebuf_q[col_q - 6'd1] <= ram_rdata;
                    end
                    if (col_q == 6'(TILE_COLS - 1)) begin
                        state_q <= StLast;
                    end else begin
                        col_q <= col_q + 6'd1;
                    end
                end
                StLast: begin
                    linebuf_q[TILE_COLS-1] <= ram_rdata;
                    state_q                <= StIdle;
                end
                StGm: begin
                    state_q    <= StIdle;
                    wr_ack_q   <= gnt_wr_q;
                    rd_ack_q   <= ~gnt_wr_q;
                    rd_valid_q <= gm_addr_ok;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pix_col = 6'((pixel_xpos - 10'd1) >> TILE_SHIFT);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pixel_data_q <= '0;
        end else if (pixel_xpos != '0 && pixel_ypos != '0 && pix_col < 6'(TILE_COLS)) begin
            pixel_data_q <= tile_colour(linebuf_q[pix_col]);
        end else begin
            pixel_data_q <= '0;
        end
    end

    assign pixel_data = pixel_data_q;
    assign gm_wr_ack  = wr_ack_q;
    assign gm_rd_ack  = rd_ack_q;
    assign gm_rd_data = (rd_ack_q && rd_valid_q) ? ram_rdata : '0;

endmodule
